// File: rtl/sample0_mac_pipe.sv
// Pipelined signed multiply-accumulate with valid/last sideband, optional accumulation,
// fixed-point output scaling and saturating or wrapping output formatting.
module sample0_mac_pipe #(
    parameter int DIN0_WIDTH = 13,
    parameter int DIN1_WIDTH = 13,
    parameter int DOUT_WIDTH = 13,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_STAGE  = 3,
    parameter int FRAC_BITS  = 0,
    parameter int SATURATE   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    input  logic                         acc_en,
    input  logic                         acc_clr,
    input  logic                         in_last,
    output logic                         out_valid,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         out_last,
    output logic                         ovf
);

    localparam int PW  = DIN0_WIDTH + DIN1_WIDTH;
    // Registers for stages 2..NUM_STAGE-1; the last entry feeds the final stage.
    localparam int DLY = NUM_STAGE - 2;
    localparam logic [DOUT_WIDTH-1:0] DOUT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [DOUT_WIDTH-1:0] DOUT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    // Stage 1
    logic signed [DIN0_WIDTH-1:0] a_q;
    logic signed [DIN1_WIDTH-1:0] b_q;
    logic                         v1_q, en1_q, clr1_q, last1_q;

    // Stages 2..NUM_STAGE-1
    logic signed [PW-1:0] p_q [DLY];
    logic [DLY-1:0]       v_q, en_q, clr_q, last_q;

    // Final stage state
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        fresh_q;

    logic signed [PW-1:0]                  prod;
    logic signed [ACC_WIDTH-1:0]           base, acc_d, shifted;
    logic [ACC_WIDTH-DOUT_WIDTH:0]         upper;
    logic                                  in_range, ovf_d;
    logic signed [DOUT_WIDTH-1:0]          dout_d;

    always_comb begin
        prod = PW'(a_q) * PW'(b_q);
    end

    always_comb begin
        base = '0;
        if (en_q[DLY-1] && !clr_q[DLY-1] && !fresh_q) begin
            base = acc_q;
        end
        acc_d    = base + ACC_WIDTH'(p_q[DLY-1]);
        shifted  = acc_d >>> FRAC_BITS;
        // In range when all discarded bits equal the output sign bit.
        upper    = shifted[ACC_WIDTH-1:DOUT_WIDTH-1];
        in_range = (upper == '0) || (upper == '1);
        ovf_d    = !in_range;
        dout_d   = shifted[DOUT_WIDTH-1:0];
        if (SATURATE != 0 && !in_range) begin
            dout_d = shifted[ACC_WIDTH-1] ? DOUT_MIN : DOUT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q      <= 1'b0;
            v_q       <= '0;
            acc_q     <= '0;
            fresh_q   <= 1'b1;
            dout      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
        end else if (ce) begin
            a_q     <= din0;
            b_q     <= din1;
            v1_q    <= in_valid;
            en1_q   <= acc_en;
            clr1_q  <= acc_clr;
            last1_q <= in_last;

            p_q[0]    <= prod;
            v_q[0]    <= v1_q;
            en_q[0]   <= en1_q;
            clr_q[0]  <= clr1_q;
            last_q[0] <= last1_q;
            for (int i = 1; i < DLY; i++) begin
                p_q[i]    <= p_q[i-1];
                v_q[i]    <= v_q[i-1];
                en_q[i]   <= en_q[i-1];
                clr_q[i]  <= clr_q[i-1];
                last_q[i] <= last_q[i-1];
            end

            if (v_q[DLY-1]) begin
                acc_q     <= acc_d;
                fresh_q   <= last_q[DLY-1];
                dout      <= dout_d;
                ovf       <= ovf_d;
                out_valid <= 1'b1;
                out_last  <= last_q[DLY-1];
            end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
